// File: rtl/lcd_spi_receiver_if.sv
// lcd_spi_receiver_if: SPI pins, FIFO output stream and status/flag signals of the LCD SPI receiver.
interface lcd_spi_receiver_if #(
  parameter int W_LEVEL = 3
);
  logic               lcd_cs;
  logic               lcd_sclk;
  logic               lcd_mosi;
  logic               lcd_dc;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         out_data;
  logic               out_dc;
  logic [W_LEVEL-1:0] level;
  logic               busy;
  logic               overflow;
  logic               frame_err;
  logic               clr_flags;
  modport slave (
    input  lcd_cs, lcd_sclk, lcd_mosi, lcd_dc, out_ready, clr_flags,
    output out_valid, out_data, out_dc, level, busy, overflow, frame_err
  );
  modport master (
    output lcd_cs, lcd_sclk, lcd_mosi, lcd_dc, out_ready, clr_flags,
    input  out_valid, out_data, out_dc, level, busy, overflow, frame_err
  );
endinterface

// File: rtl/lcd_spi_receiver.sv
// lcd_spi_receiver: SPI mode-0 LCD byte receiver with pin synchronizers and a first-word-fall-through FIFO.
module lcd_spi_receiver #(
  parameter int FIFO_DEPTH = 4,
  parameter int W_LEVEL    = 3
) (
  input logic               clk,
  input logic               rst_n,
  lcd_spi_receiver_if.slave bus
);
  localparam int AW = W_LEVEL - 1;
  localparam logic [W_LEVEL-1:0] FULL_LEVEL = W_LEVEL'(FIFO_DEPTH);
  logic [2:0]         r_cs_s, r_sclk_s;
  logic [1:0]         r_mosi_s, r_dc_s;
  logic [2:0]         r_cnt;
  logic [6:0]         r_sh;
  logic               r_push, r_push_dc;
  logic [7:0]         r_push_data;
  logic [8:0]         r_mem [FIFO_DEPTH];
  logic [W_LEVEL-1:0] r_wptr, r_rptr;
  logic               r_ovf, r_ferr;
  logic               w_cs, w_sclk_rise, w_cs_rise;
  logic               w_valid, w_full, w_pop, w_wr, w_drop;
  logic [W_LEVEL-1:0] w_level;
  logic [8:0]         w_head;
  // Chip select resets high so the bus looks idle and no edge is seen on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_s   <= 3'b111;
      r_sclk_s <= '0;
      r_mosi_s <= '0;
      r_dc_s   <= '0;
    end else begin
      r_cs_s   <= {r_cs_s[1:0], bus.lcd_cs};
      r_sclk_s <= {r_sclk_s[1:0], bus.lcd_sclk};
      r_mosi_s <= {r_mosi_s[0], bus.lcd_mosi};
      r_dc_s   <= {r_dc_s[0], bus.lcd_dc};
    end
  end
  assign w_cs        = r_cs_s[1];
  assign w_cs_rise   = r_cs_s[1] & ~r_cs_s[2];
  assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_s[2] & ~w_cs;
  // The completed byte is staged one cycle before entering the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_sh        <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_push_dc   <= 1'b0;
    end else begin
      r_push <= w_sclk_rise && r_cnt == 3'd7;
      if (w_sclk_rise) begin
        r_push_data <= {r_sh, r_mosi_s[1]};
        r_push_dc   <= r_dc_s[1];
      end
      if (w_cs) begin
        r_cnt <= '0;
        r_sh  <= '0;
      end else if (w_sclk_rise) begin
        r_cnt <= r_cnt + 3'd1;
        r_sh  <= {r_sh[5:0], r_mosi_s[1]};
      end
    end
  end
  assign w_level = r_wptr - r_rptr;
  assign w_valid = w_level != '0;
  assign w_full  = w_level == FULL_LEVEL;
  assign w_pop   = w_valid & bus.out_ready;
  assign w_wr    = r_push & (~w_full | w_pop);
  assign w_drop  = r_push & w_full & ~w_pop;
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= {r_push_dc, r_push_data};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_ovf  <= w_drop | (r_ovf & ~bus.clr_flags);
      r_ferr <= (w_cs_rise && r_cnt != 3'd0) | (r_ferr & ~bus.clr_flags);
    end
  end
  assign w_head        = w_valid ? r_mem[r_rptr[AW-1:0]] : '0;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_head[7:0];
  assign bus.out_dc    = w_head[8];
  assign bus.level     = w_level;
  assign bus.busy      = ~w_cs;
  assign bus.overflow  = r_ovf;
  assign bus.frame_err = r_ferr;
endmodule

// File: tb/tb_lcd_spi_receiver.sv
// tb_lcd_spi_receiver: directed SPI byte sequences with hand-computed FIFO contents, flags and latency.
module tb_lcd_spi_receiver;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_total = 0;
  int n_fail = 0;
  lcd_spi_receiver_if #(.W_LEVEL(3)) bus ();
  lcd_spi_receiver #(.FIFO_DEPTH(4), .W_LEVEL(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #10 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bit(input logic b);
    bus.lcd_sclk = 1'b0;
    bus.lcd_mosi = b;
    cycles(5);
    bus.lcd_sclk = 1'b1;
    cycles(5);
  endtask
  // lat: check out_valid timing (FIFO empty beforehand); pr: pulse out_ready on the push edge
  task automatic send_byte(input logic [7:0] d, input logic dc, input logic lat, input logic pr);
    bus.lcd_dc = dc;
    for (int i = 7; i > 0; i--) send_bit(d[i]);
    bus.lcd_sclk = 1'b0;
    bus.lcd_mosi = d[0];
    cycles(5);
    bus.lcd_sclk = 1'b1;
    cycles(3);
    if (lat) chk("latency_before", 32'(bus.out_valid), 32'd0);
    bus.out_ready = pr;
    cycles(1);
    bus.out_ready = 1'b0;
    if (lat) chk("latency_at", 32'(bus.out_valid), 32'd1);
    cycles(1);
  endtask
  task automatic pop(input logic [7:0] d, input logic dc);
    chk("pop_valid", 32'(bus.out_valid), 32'd1);
    chk("pop_data", 32'(bus.out_data), 32'(d));
    chk("pop_dc", 32'(bus.out_dc), 32'(dc));
    bus.out_ready = 1'b1;
    cycles(1);
    bus.out_ready = 1'b0;
  endtask
  task automatic clear_flags();
    bus.clr_flags = 1'b1;
    cycles(1);
    bus.clr_flags = 1'b0;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_level"}, 32'(bus.level), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
    chk({tag, "_ferr"}, 32'(bus.frame_err), 32'd0);
    chk({tag, "_data"}, 32'(bus.out_data), 32'd0);
    chk({tag, "_dc"}, 32'(bus.out_dc), 32'd0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end
  initial begin
    bus.lcd_cs = 1'b1;
    bus.lcd_sclk = 1'b0;
    bus.lcd_mosi = 1'b0;
    bus.lcd_dc = 1'b0;
    bus.out_ready = 1'b0;
    bus.clr_flags = 1'b0;
    #2 rst_n = 1'b0;
    #3 chk_reset_outputs("rst");
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
    // single byte, latency and contents
    bus.lcd_cs = 1'b0;
    cycles(3);
    chk("busy_on", 32'(bus.busy), 32'd1);
    send_byte(8'h2A, 1'b0, 1'b1, 1'b0);
    chk("b1_level", 32'(bus.level), 32'd1);
    chk("b1_ovf", 32'(bus.overflow), 32'd0);
    chk("b1_ferr", 32'(bus.frame_err), 32'd0);
    pop(8'h2A, 1'b0);
    chk("b1_empty", 32'(bus.level), 32'd0);
    // overflow on a fifth byte
    for (int i = 0; i < 5; i++) send_byte(8'(17 * (i + 1)), 1'b1, 1'b0, 1'b0);
    chk("ovf_level", 32'(bus.level), 32'd4);
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 4; i++) pop(8'(17 * (i + 1)), 1'b1);
    chk("ovf_drained", 32'(bus.level), 32'd0);
    clear_flags();
    chk("ovf_clr", 32'(bus.overflow), 32'd0);
    // truncated byte then good byte
    bus.lcd_dc = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    bus.lcd_cs = 1'b1;
    cycles(4);
    chk("fe_set", 32'(bus.frame_err), 32'd1);
    chk("fe_level", 32'(bus.level), 32'd0);
    chk("fe_busy", 32'(bus.busy), 32'd0);
    bus.lcd_cs = 1'b0;
    cycles(3);
    send_byte(8'h81, 1'b0, 1'b1, 1'b0);
    chk("fe_only_one", 32'(bus.level), 32'd1);
    pop(8'h81, 1'b0);
    chk("fe_empty", 32'(bus.level), 32'd0);
    clear_flags();
    chk("fe_clr", 32'(bus.frame_err), 32'd0);
    // push into full FIFO on the same edge as a pop
    for (int i = 0; i < 4; i++) send_byte(8'(i + 1), 1'b0, 1'b0, 1'b0);
    chk("full_level", 32'(bus.level), 32'd4);
    send_byte(8'h05, 1'b0, 1'b0, 1'b1);
    chk("pp_level", 32'(bus.level), 32'd4);
    chk("pp_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 4; i++) pop(8'(i + 2), 1'b0);
    chk("pp_empty", 32'(bus.level), 32'd0);
    // reset mid-byte
    send_byte(8'h10, 1'b0, 1'b0, 1'b0);
    send_byte(8'h20, 1'b0, 1'b0, 1'b0);
    chk("mid_level", 32'(bus.level), 32'd2);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    bus.lcd_sclk = 1'b0;
    rst_n = 1'b0;
    #1 chk_reset_outputs("mid_rst");
    cycles(2);
    rst_n = 1'b1;
    cycles(3);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    send_byte(8'hA5, 1'b1, 1'b1, 1'b0);
    chk("rst_level", 32'(bus.level), 32'd1);
    chk("rst_ferr", 32'(bus.frame_err), 32'd0);
    pop(8'hA5, 1'b1);
    // sclk activity while deselected
    bus.lcd_cs = 1'b1;
    bus.lcd_mosi = 1'b1;
    cycles(3);
    for (int i = 0; i < 8; i++) begin
      bus.lcd_sclk = 1'b1;
      cycles(3);
      bus.lcd_sclk = 1'b0;
      cycles(3);
    end
    chk("idle_level", 32'(bus.level), 32'd0);
    chk("idle_ovf", 32'(bus.overflow), 32'd0);
    chk("idle_ferr", 32'(bus.frame_err), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end
endmodule
